// File: rtl/sort_mem_sched.sv
// rtl/sort_mem_sched.sv - quick-sort job sequencer sharing a single-port sort RAM with a host port
module sort_mem_sched #(
  parameter int MM = 256,
  parameter int MN = 32,
  parameter int MW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_start,
  input  logic [MW:0]   cmd_num,
  output logic          cmd_ready,
  output logic          busy,
  output logic          job_done,
  output logic [1:0]    job_err,
  output logic [31:0]   job_cycles,
  output logic [15:0]   job_cnt,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [MW-1:0] h_addr,
  input  logic [MN-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [MN-1:0] h_rdata,
  output logic          qs_start,
  output logic [MW:0]   qs_num,
  input  logic          qs_done,
  input  logic          qs_wr,
  input  logic          qs_rd,
  input  logic [MW-1:0] qs_wr_addr,
  input  logic [MW-1:0] qs_rd_addr,
  input  logic [MN-1:0] qs_wr_data,
  output logic [MN-1:0] qs_rd_data,
  output logic          mem_we,
  output logic          mem_re,
  output logic [MW-1:0] mem_addr,
  output logic [MN-1:0] mem_wdata,
  input  logic [MN-1:0] mem_rdata
);

  localparam logic [MW:0] MAX_LEN = MM[MW:0];

  typedef enum logic [2:0] {IDLE, DRAIN, KICK, RUN, FIN} state_t;

  state_t      state;
  logic [MW:0] num_r;
  logic [31:0] cyc;
  logic [31:0] cyc_inc;
  logic        spur;
  logic        spur_now;
  logic        eng_own;
  logic        fin_go;
  logic [1:0]  fin_err;

  assign eng_own    = (state == KICK) || (state == RUN);
  // A simultaneous read+write by the engine counts as a protocol violation too.
  assign spur_now   = eng_own ? (qs_wr & qs_rd) : (qs_wr | qs_rd);
  assign cyc_inc    = (cyc == '1) ? cyc : cyc + 32'd1;
  assign h_gnt      = h_req && (state == IDLE);
  assign qs_num     = num_r;
  assign qs_rd_data = mem_rdata;
  assign h_rdata    = h_rvalid ? mem_rdata : '0;

  always_comb begin
    if (eng_own) begin
      mem_we    = qs_wr;
      mem_re    = qs_rd & ~qs_wr;
      mem_addr  = qs_wr ? qs_wr_addr : qs_rd_addr;
      mem_wdata = qs_wr_data;
    end else begin
      mem_we    = h_gnt & h_we;
      mem_re    = h_gnt & ~h_we;
      mem_addr  = h_addr;
      mem_wdata = h_wdata;
    end
  end

  always_comb begin
    fin_go  = 1'b0;
    fin_err = (spur | spur_now) ? 2'd2 : 2'd0;
    if (state == IDLE && cmd_start && (cmd_num > MAX_LEN || cmd_num[MW:1] == '0)) begin
      fin_go = 1'b1;
      if (cmd_num > MAX_LEN) fin_err = 2'd1;
    end else if (state == RUN && qs_done) begin
      fin_go = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      job_done   <= 1'b0;
      job_err    <= 2'd0;
      job_cycles <= '0;
      job_cnt    <= '0;
      qs_start   <= 1'b0;
      h_rvalid   <= 1'b0;
      num_r      <= '0;
      cyc        <= '0;
      spur       <= 1'b0;
    end else begin
      job_done <= fin_go;
      qs_start <= 1'b0;
      h_rvalid <= h_gnt & ~h_we;
      // Status is published on entry to FIN so it lines up with job_done.
      if (fin_go) begin
        job_err    <= fin_err;
        job_cycles <= (state == RUN) ? cyc_inc : '0;
        job_cnt    <= job_cnt + 16'd1;
        spur       <= 1'b0;
      end else if (spur_now) begin
        spur <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (cmd_start) begin
            num_r     <= cmd_num;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= fin_go ? FIN : DRAIN;
          end
        end
        DRAIN: begin
          cyc      <= '0;
          qs_start <= 1'b1;
          state    <= KICK;
        end
        KICK: begin
          cyc   <= cyc_inc;
          state <= RUN;
        end
        RUN: begin
          cyc <= cyc_inc;
          if (qs_done) state <= FIN;
        end
        FIN: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_mem_sched.sv
// tb/tb_sort_mem_sched.sv - randomized bench for sort_mem_sched with RAM, engine and host models
module tb_sort_mem_sched;

  logic        clk;
  logic        reset_n;
  logic        cmd_start;
  logic [8:0]  cmd_num;
  logic        cmd_ready, busy, job_done;
  logic [1:0]  job_err;
  logic [31:0] job_cycles;
  logic [15:0] job_cnt;
  logic        h_req, h_we;
  logic [7:0]  h_addr;
  logic [31:0] h_wdata;
  logic        h_gnt, h_rvalid;
  logic [31:0] h_rdata;
  logic        qs_start;
  logic [8:0]  qs_num;
  logic        qs_done, qs_wr, qs_rd;
  logic [7:0]  qs_wr_addr, qs_rd_addr;
  logic [31:0] qs_wr_data, qs_rd_data;
  logic        mem_we, mem_re;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  sort_mem_sched dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_num(cmd_num), .cmd_ready(cmd_ready), .busy(busy),
    .job_done(job_done), .job_err(job_err), .job_cycles(job_cycles), .job_cnt(job_cnt),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .qs_start(qs_start), .qs_num(qs_num), .qs_done(qs_done), .qs_wr(qs_wr), .qs_rd(qs_rd),
    .qs_wr_addr(qs_wr_addr), .qs_rd_addr(qs_rd_addr), .qs_wr_data(qs_wr_data),
    .qs_rd_data(qs_rd_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  longint      tcyc = 0;
  longint      acc_t = 0;
  int          exp_cnt = 0;
  int          gnt_busy = 0;
  int          nstart = 0;
  int          ndone = 0;
  logic        eng_stall = 1'b0;
  logic        eng_conflict = 1'b0;
  int          en;
  logic [31:0] ebuf [256];
  logic [31:0] ram [256];
  logic [31:0] model [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) tcyc++;

  // Single-port RAM, write has priority, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (mem_re) mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (busy && h_gnt) gnt_busy++;
    if (qs_start) nstart++;
    if (job_done) ndone++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Engine: read all elements, sort locally, write them back, pulse done.
  initial begin
    qs_wr = 0; qs_rd = 0; qs_done = 0; qs_wr_addr = 0; qs_rd_addr = 0; qs_wr_data = 0;
    forever begin
      @(negedge clk);
      if (qs_start && !eng_stall) begin
        en = int'(qs_num);
        for (int i = 0; i < en; i++) begin
          @(posedge clk); #1 qs_rd = 1; qs_rd_addr = i[7:0];
          @(posedge clk); #1 qs_rd = 0;
          @(negedge clk); ebuf[i] = qs_rd_data;
        end
        for (int a = 0; a < en - 1; a++)
          for (int b = 0; b < en - 1 - a; b++)
            if (ebuf[b] > ebuf[b+1]) begin
              logic [31:0] t;
              t = ebuf[b]; ebuf[b] = ebuf[b+1]; ebuf[b+1] = t;
            end
        for (int i = 0; i < en; i++) begin
          @(posedge clk); #1 qs_wr = 1; qs_wr_addr = i[7:0]; qs_wr_data = ebuf[i];
          qs_rd = eng_conflict && (i == 0); qs_rd_addr = 8'd200;
        end
        @(posedge clk); #1 qs_wr = 0; qs_rd = 0; qs_done = 1;
        @(posedge clk); #1 qs_done = 0;
      end
    end
  end

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    int t;
    @(posedge clk); #1 h_req = 1; h_we = 1; h_addr = a; h_wdata = d;
    t = 0;
    @(negedge clk);
    while (!h_gnt && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk("wr_gnt_timeout", h_gnt, 1);
    @(posedge clk); #1 h_req = 0; h_we = 0;
    model[a] = d;
  endtask

  task automatic host_read(input logic [7:0] a, output logic [31:0] d, output longint gt);
    int t;
    @(posedge clk); #1 h_req = 1; h_we = 0; h_addr = a;
    t = 0;
    @(negedge clk);
    while (!h_gnt && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) chk("rd_gnt_timeout", h_gnt, 1);
    gt = tcyc;
    @(posedge clk); #1 h_req = 0;
    @(negedge clk);
    chk("rvalid_after_gnt", h_rvalid, 1);
    d = h_rdata;
  endtask

  task automatic start_job(input int n);
    @(posedge clk); #1 cmd_start = 1; cmd_num = n[8:0];
    @(negedge clk); acc_t = tcyc;
    @(posedge clk); #1 cmd_start = 0;
  endtask

  task automatic wait_done(output int dk, output int sk, output longint dt);
    dk = -1; sk = -1; dt = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (qs_start && sk < 0) sk = int'(tcyc - acc_t);
      if (job_done) begin dk = int'(tcyc - acc_t); dt = tcyc; break; end
    end
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) host_write(i[7:0], $urandom);
  endtask

  task automatic check_sorted(input string tag, input int n);
    int unsigned q[$];
    int errs;
    logic [31:0] d;
    longint gt;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(model[i]);
    q.sort();
    errs = 0;
    for (int i = 0; i < n; i++) begin
      host_read(i[7:0], d, gt);
      if (d !== q[i]) errs++;
      model[i] = q[i];
    end
    chk(tag, errs, 0);
  endtask

  task automatic run_job(input int n, input logic [1:0] exp_err);
    int dk, sk;
    longint dt;
    start_job(n);
    wait_done(dk, sk, dt);
    exp_cnt++;
    chk("job_done_seen", dk > 0, 1);
    chk("qs_start_latency", sk, 2);
    chk("job_err", job_err, exp_err);
    chk("job_cycles", job_cycles, 3 * n + 2);
    chk("job_cnt", job_cnt, exp_cnt[15:0]);
    chk("qs_num_held", qs_num, n);
    @(negedge clk);
    chk("job_done_one_cycle", job_done, 0);
  endtask

  task automatic run_skip(input int n, input logic [1:0] exp_err);
    int dk, sk, s0;
    longint dt;
    s0 = nstart;
    start_job(n);
    wait_done(dk, sk, dt);
    exp_cnt++;
    chk("skip_done_latency", dk, 1);
    chk("skip_err", job_err, exp_err);
    chk("skip_cycles", job_cycles, 0);
    chk("skip_no_qs_start", nstart - s0, 0);
    chk("skip_cnt", job_cnt, exp_cnt[15:0]);
  endtask

  initial begin
    int dk, sk, n, a, d0;
    longint dt, gt;
    logic [31:0] d;
    logic [31:0] exp4 [4];
    exp4 = '{32'd1, 32'd3, 32'd5, 32'd9};
    reset_n = 0; cmd_start = 0; cmd_num = 0;
    h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_job_err", job_err, 0);
    chk("rst_job_cycles", job_cycles, 0);
    chk("rst_job_cnt", job_cnt, 0);
    chk("rst_qs_num", qs_num, 0);
    chk("rst_h_rvalid", h_rvalid, 0);
    chk("rst_qs_start", qs_start, 0);
    @(posedge clk); #1 reset_n = 1;

    // Directed 4-element sort with a host read of address 7 held through the job.
    host_write(8'd0, 32'd5); host_write(8'd1, 32'd3);
    host_write(8'd2, 32'd9); host_write(8'd3, 32'd1);
    host_write(8'd7, 32'd777);
    start_job(4);
    fork
      wait_done(dk, sk, dt);
      begin repeat (5) @(posedge clk); host_read(8'd7, d, gt); end
    join
    exp_cnt++;
    chk("t1_qs_start_latency", sk, 2);
    chk("t1_job_err", job_err, 0);
    chk("t1_job_cnt", job_cnt, exp_cnt[15:0]);
    chk("t1_job_cycles", job_cycles, 14);
    chk("t1_held_gnt_first_idle", gt, dt + 1);
    chk("t1_held_rdata", d, 777);
    for (int i = 0; i < 4; i++) begin
      host_read(i[7:0], d, gt);
      chk("t1_readback", d, exp4[i]);
      model[i] = exp4[i];
    end

    run_skip(257, 2'd1);
    run_skip(1, 2'd0);
    run_skip(0, 2'd0);

    // Host read and command in the same IDLE cycle.
    load_random(5);
    a = $urandom_range(0, 4);
    @(posedge clk); #1 cmd_start = 1; cmd_num = 9'd5; h_req = 1; h_we = 0; h_addr = a[7:0];
    @(negedge clk);
    chk("same_h_gnt", h_gnt, 1);
    acc_t = tcyc;
    @(posedge clk); #1 cmd_start = 0; h_req = 0;
    @(negedge clk);
    chk("same_rvalid_drain", h_rvalid, 1);
    chk("same_rdata", h_rdata, model[a]);
    chk("same_no_start_drain", qs_start, 0);
    @(negedge clk);
    chk("same_start_kick", qs_start, 1);
    wait_done(dk, sk, dt);
    exp_cnt++;
    chk("same_err", job_err, 0);
    chk("same_cnt", job_cnt, exp_cnt[15:0]);
    check_sorted("same_sorted", 5);

    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(2, 24);
      load_random(n);
      run_job(n, 2'd0);
      check_sorted("rand_sorted", n);
    end
    load_random(2);
    run_job(2, 2'd0);
    check_sorted("min_len_sorted", 2);
    load_random(256);
    run_job(256, 2'd0);
    check_sorted("max_len_sorted", 256);

    // Engine read/write collision: write wins, error reported, then cleared.
    eng_conflict = 1;
    n = $urandom_range(3, 10);
    load_random(n);
    run_job(n, 2'd2);
    check_sorted("conflict_sorted", n);
    eng_conflict = 0;
    load_random(n);
    run_job(n, 2'd0);
    check_sorted("after_conflict_sorted", n);
    chk("no_gnt_while_busy", gnt_busy, 0);

    // Reset in the middle of a stalled job.
    eng_stall = 1;
    start_job(6);
    repeat (6) @(negedge clk);
    chk("stall_busy", busy, 1);
    @(posedge clk); #1 h_req = 1; h_we = 0; h_addr = 8'd7;
    @(negedge clk);
    chk("stall_h_gnt", h_gnt, 0);
    d0 = ndone;
    @(posedge clk); #1 reset_n = 0; h_req = 0;
    @(negedge clk);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_job_cnt", job_cnt, 0);
    @(posedge clk); #1 reset_n = 1; eng_stall = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_job_done", ndone - d0, 0);
    chk("midrst_idle", cmd_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
